register_file_mp: RTL and testbench

- Parametrised successor to the 32x32 single-write register file.
- Width and depth are configurable. Two write ports with defined collision priority. Optional hardwired zero register. Optional read-during-write bypass.
- A per-register pending (scoreboard) bit lets the pipeline control stall on operands whose writeback is outstanding.
- Sits between decode (ASEL/BSEL, ISSUE) and writeback (two result buses: ALU and load).

---
 rtl/register_file_mp.sv | 86 ++++++++
 tb/tb_register_file_mp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Parametrised two-write-port register file with read-during-write bypass,
// optional hardwired zero register, and a per-register pending scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WR0,
  input  logic [ADDR_W-1:0] DSEL0,
  input  logic [DATA_W-1:0] DIN0,
  input  logic              WR1,
  input  logic [ADDR_W-1:0] DSEL1,
  input  logic [DATA_W-1:0] DIN1,
  input  logic [ADDR_W-1:0] ASEL,
  input  logic [ADDR_W-1:0] BSEL,
  output logic [DATA_W-1:0] AOUT,
  output logic [DATA_W-1:0] BOUT,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_SEL,
  output logic              ABUSY,
  output logic              BBUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic zero_d0, zero_d1, zero_is, zero_a, zero_b;

  always_comb begin
    zero_d0 = (ZERO_REG != 0) && (DSEL0 == '0);
    zero_d1 = (ZERO_REG != 0) && (DSEL1 == '0);
    zero_is = (ZERO_REG != 0) && (ISSUE_SEL == '0);
    zero_a  = (ZERO_REG != 0) && (ASEL == '0);
    zero_b  = (ZERO_REG != 0) && (BSEL == '0);
  end

  // Port 0 is suppressed on an address collision so port 1 wins cleanly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (WR0 && !zero_d0 && !(WR1 && (DSEL1 == DSEL0))) regs[DSEL0] <= DIN0;
      if (WR1 && !zero_d1) regs[DSEL1] <= DIN1;
    end
  end

  // Issue is applied after the writeback clears so a same-cycle set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      if (WR0) pending[DSEL0] <= 1'b0;
      if (WR1) pending[DSEL1] <= 1'b0;
      if (ISSUE && !zero_is) pending[ISSUE_SEL] <= 1'b1;
    end
  end

  always_comb begin
    AOUT = regs[ASEL];
    if (BYPASS != 0) begin
      if (WR0 && (DSEL0 == ASEL)) AOUT = DIN0;
      if (WR1 && (DSEL1 == ASEL)) AOUT = DIN1;
    end
    if (zero_a || !reset) AOUT = '0;
  end

  always_comb begin
    BOUT = regs[BSEL];
    if (BYPASS != 0) begin
      if (WR0 && (DSEL0 == BSEL)) BOUT = DIN0;
      if (WR1 && (DSEL1 == BSEL)) BOUT = DIN1;
    end
    if (zero_b || !reset) BOUT = '0;
  end

  always_comb begin
    ABUSY = reset && pending[ASEL] && !zero_a;
    BBUSY = reset && pending[BSEL] && !zero_b;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised bench for register_file_mp: a default instance, a no-bypass
// instance sharing its stimulus, and a small 16x8 instance without zero register.
module tb_register_file_mp;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Stimulus shared by u0 (BYPASS=1) and u1 (BYPASS=0), both 32x32 with zero reg.
  logic        WR0 = 0, WR1 = 0, ISSUE = 0;
  logic [4:0]  DSEL0 = 0, DSEL1 = 0, ASEL = 0, BSEL = 0, ISSUE_SEL = 0;
  logic [31:0] DIN0 = 0, DIN1 = 0;
  logic [31:0] AOUT0, BOUT0, AOUT1, BOUT1;
  logic        ABUSY0, BBUSY0, ABUSY1, BBUSY1;

  // Stimulus for u2: 16-bit, 8 entries, no zero register, bypass on.
  logic        WR0s = 0, WR1s = 0, ISSUEs = 0;
  logic [2:0]  DSEL0s = 0, DSEL1s = 0, ASELs = 0, BSELs = 0, ISSUE_SELs = 0;
  logic [15:0] DIN0s = 0, DIN1s = 0;
  logic [15:0] AOUT2, BOUT2;
  logic        ABUSY2, BBUSY2;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clock(clock), .reset(reset), .WR0(WR0), .DSEL0(DSEL0), .DIN0(DIN0),
    .WR1(WR1), .DSEL1(DSEL1), .DIN1(DIN1), .ASEL(ASEL), .BSEL(BSEL),
    .AOUT(AOUT0), .BOUT(BOUT0), .ISSUE(ISSUE), .ISSUE_SEL(ISSUE_SEL),
    .ABUSY(ABUSY0), .BBUSY(BBUSY0));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clock(clock), .reset(reset), .WR0(WR0), .DSEL0(DSEL0), .DIN0(DIN0),
    .WR1(WR1), .DSEL1(DSEL1), .DIN1(DIN1), .ASEL(ASEL), .BSEL(BSEL),
    .AOUT(AOUT1), .BOUT(BOUT1), .ISSUE(ISSUE), .ISSUE_SEL(ISSUE_SEL),
    .ABUSY(ABUSY1), .BBUSY(BBUSY1));

  register_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u2 (
    .clock(clock), .reset(reset), .WR0(WR0s), .DSEL0(DSEL0s), .DIN0(DIN0s),
    .WR1(WR1s), .DSEL1(DSEL1s), .DIN1(DIN1s), .ASEL(ASELs), .BSEL(BSELs),
    .AOUT(AOUT2), .BOUT(BOUT2), .ISSUE(ISSUEs), .ISSUE_SEL(ISSUE_SELs),
    .ABUSY(ABUSY2), .BBUSY(BBUSY2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of stored values and pending flags.
  logic [31:0] m  [32];
  bit          p  [32];
  logic [15:0] ms [8];
  bit          ps [8];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin m[i] = 0; p[i] = 0; end
      for (int i = 0; i < 8; i++) begin ms[i] = 0; ps[i] = 0; end
    end else begin
      if (WR0 && DSEL0 != 0) m[DSEL0] = DIN0;
      if (WR1 && DSEL1 != 0) m[DSEL1] = DIN1;
      if (WR0) p[DSEL0] = 0;
      if (WR1) p[DSEL1] = 0;
      if (ISSUE && ISSUE_SEL != 0) p[ISSUE_SEL] = 1;
      if (WR0s) ms[DSEL0s] = DIN0s;
      if (WR1s) ms[DSEL1s] = DIN1s;
      if (WR0s) ps[DSEL0s] = 0;
      if (WR1s) ps[DSEL1s] = 0;
      if (ISSUEs) ps[ISSUE_SELs] = 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!reset || a == 0) return 32'h0;
    if (byp && WR1 && DSEL1 == a) return DIN1;
    if (byp && WR0 && DSEL0 == a) return DIN0;
    return m[a];
  endfunction

  function automatic logic [15:0] exp_rds(input logic [2:0] a);
    if (!reset) return 16'h0;
    if (WR1s && DSEL1s == a) return DIN1s;
    if (WR0s && DSEL0s == a) return DIN0s;
    return ms[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return reset && p[a];
  endfunction

  always @(negedge clock) begin
    chk("u0_aout", AOUT0, exp_rd(ASEL, 1));
    chk("u0_bout", BOUT0, exp_rd(BSEL, 1));
    chk("u1_aout", AOUT1, exp_rd(ASEL, 0));
    chk("u1_bout", BOUT1, exp_rd(BSEL, 0));
    chk("u0_abusy", {31'b0, ABUSY0}, {31'b0, exp_busy(ASEL)});
    chk("u0_bbusy", {31'b0, BBUSY0}, {31'b0, exp_busy(BSEL)});
    chk("u1_abusy", {31'b0, ABUSY1}, {31'b0, exp_busy(ASEL)});
    chk("u2_aout", {16'b0, AOUT2}, {16'b0, exp_rds(ASELs)});
    chk("u2_bout", {16'b0, BOUT2}, {16'b0, exp_rds(BSELs)});
    chk("u2_abusy", {31'b0, ABUSY2}, {31'b0, reset && ps[ASELs]});
    chk("u2_bbusy", {31'b0, BBUSY2}, {31'b0, reset && ps[BSELs]});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    WR0 = 0; WR1 = 0; ISSUE = 0; WR0s = 0; WR1s = 0; ISSUEs = 0;
  endtask

  initial begin
    // Reset held three cycles while sweeping read addresses.
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 32; a++) begin
        ASEL = 5'(a); BSEL = 5'(31 - a); #0.1;
        chk("rst_aout", AOUT0, 0);
        chk("rst_bout", BOUT0, 0);
        chk("rst_busy", {30'b0, ABUSY0, BBUSY0}, 0);
      end
      tick();
    end
    reset = 1;
    tick();

    // Fill and readback.
    for (int i = 1; i < 32; i++) begin
      WR0 = 1; DSEL0 = 5'(i); DIN0 = 32'(i * 3); tick();
    end
    DSEL0 = 0; DIN0 = 32'hDEADBEEF; tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      ASEL = 5'(i); BSEL = 5'(i); #1;
      chk("fill_a", AOUT0, (i == 0) ? 32'h0 : 32'(i * 3));
      chk("fill_b", BOUT1, (i == 0) ? 32'h0 : 32'(i * 3));
    end

    // Collision: port 1 wins; distinct addresses both land.
    WR0 = 1; WR1 = 1; DSEL0 = 7; DSEL1 = 7; DIN0 = 32'h11111111; DIN1 = 32'h22222222;
    tick();
    DSEL0 = 3; DSEL1 = 4; DIN0 = 32'hA; DIN1 = 32'hB; ASEL = 7; #1;
    chk("collide", AOUT1, 32'h22222222);
    tick(); idle();
    ASEL = 3; BSEL = 4; #1;
    chk("reg3", AOUT1, 32'hA);
    chk("reg4", BOUT1, 32'hB);

    // Bypass versus stored read.
    ASEL = 9; WR1 = 1; DSEL1 = 9; DIN1 = 32'h55; #1;
    chk("byp_on", AOUT0, 32'h55);
    chk("byp_off_old", AOUT1, 32'h1B);
    tick(); idle(); #1;
    chk("byp_off_new", AOUT1, 32'h55);

    // Scoreboard.
    ISSUE = 1; ISSUE_SEL = 12; tick(); idle();
    ASEL = 12; #1;
    chk("sb_set", {31'b0, ABUSY0}, 1);
    WR0 = 1; DSEL0 = 12; DIN0 = 32'h99; tick(); idle(); #1;
    chk("sb_clr", {31'b0, ABUSY0}, 0);
    ISSUE = 1; ISSUE_SEL = 12; WR1 = 1; DSEL1 = 12; DIN1 = 32'h77; tick(); idle(); #1;
    chk("sb_setwins_data", AOUT1, 32'h77);
    chk("sb_setwins_busy", {31'b0, ABUSY0}, 1);
    ISSUE = 1; ISSUE_SEL = 0; tick(); idle();
    ASEL = 0; #1;
    chk("sb_zero", {31'b0, ABUSY0}, 0);

    // Small instance, no zero register.
    WR0s = 1; DSEL0s = 0; DIN0s = 16'hFFFF; tick();
    DSEL0s = 7; tick(); idle();
    ASELs = 0; BSELs = 7; #1;
    chk("small_r0", {16'b0, AOUT2}, 32'hFFFF);
    chk("small_r7", {16'b0, BOUT2}, 32'hFFFF);

    // Mid-cycle asynchronous reset after writes.
    ASEL = 12; BSEL = 3; #1;
    reset = 0; #1;
    chk("async_aout", AOUT0, 0);
    chk("async_bout", BOUT1, 0);
    chk("async_busy", {31'b0, ABUSY0}, 0);
    chk("async_small", {16'b0, BOUT2}, 0);
    tick(); reset = 1; tick();

    // Randomised traffic, with addresses biased to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      WR0 = 1'($urandom); WR1 = 1'($urandom); ISSUE = ($urandom_range(0, 3) == 0);
      DSEL0 = 5'($urandom_range(0, 7)); DSEL1 = 5'($urandom_range(0, 7));
      ISSUE_SEL = 5'($urandom_range(0, 7));
      ASEL = ($urandom_range(0, 1) != 0) ? DSEL1 : 5'($urandom_range(0, 31));
      BSEL = ($urandom_range(0, 1) != 0) ? DSEL0 : 5'($urandom_range(0, 31));
      DIN0 = $urandom; DIN1 = $urandom;
      WR0s = 1'($urandom); WR1s = 1'($urandom); ISSUEs = ($urandom_range(0, 3) == 0);
      DSEL0s = 3'($urandom); DSEL1s = 3'($urandom); ISSUE_SELs = 3'($urandom);
      ASELs = 3'($urandom); BSELs = ($urandom_range(0, 1) != 0) ? DSEL1s : 3'($urandom);
      DIN0s = 16'($urandom); DIN1s = 16'($urandom);
      if (c % 700 == 699) begin
        #2 reset = 0;
        #1 chk("rand_async", AOUT0, 0);
        #2 reset = 1;
      end
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
